// File: rtl/dist_sq_seq.sv
// dist_sq_seq: sequential shift-add squared distance (x-cx)^2 + (y-cy)^2,
// saturated to OUT_WIDTH bits, feeding the downstream square-root stage.
module dist_sq_seq #(
    parameter int COORD_WIDTH = 10,
    parameter int OUT_WIDTH   = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COORD_WIDTH-1:0] x_in,
    input  logic [COORD_WIDTH-1:0] y_in,
    input  logic [COORD_WIDTH-1:0] cx_in,
    input  logic [COORD_WIDTH-1:0] cy_in,
    input  logic                   start,
    output logic [OUT_WIDTH-1:0]   sq_out,
    output logic                   overflow,
    output logic                   done,
    output logic                   finish
);

    localparam int ACC_W = 2 * COORD_WIDTH + 1;
    localparam int CNT_W = (COORD_WIDTH > 1) ? $clog2(COORD_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ_X = 2'd1,
        SQ_Y = 2'd2,
        SAT  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [COORD_WIDTH-1:0] dx_q, dx_d;
    logic [COORD_WIDTH-1:0] dy_q, dy_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [OUT_WIDTH-1:0]   sq_out_q, sq_out_d;
    logic                   overflow_q, overflow_d;
    logic                   done_q, done_d;

    logic [COORD_WIDTH-1:0] operand;
    logic                   last_bit;

    assign operand  = (state_q == SQ_X) ? dx_q : dy_q;
    assign last_bit = (bit_cnt_q == CNT_W'(COORD_WIDTH - 1));

    // State register and datapath flops; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            dx_q       <= '0;
            dy_q       <= '0;
            acc_q      <= '0;
            bit_cnt_q  <= '0;
            sq_out_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            acc_q      <= acc_d;
            bit_cnt_q  <= bit_cnt_d;
            sq_out_q   <= sq_out_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // Next-state, shift-add accumulation and saturating result load.
    always_comb begin
        state_d    = state_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        acc_d      = acc_q;
        bit_cnt_d  = bit_cnt_q;
        sq_out_d   = sq_out_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dx_d      = (x_in >= cx_in) ? (x_in - cx_in) : (cx_in - x_in);
                    dy_d      = (y_in >= cy_in) ? (y_in - cy_in) : (cy_in - y_in);
                    acc_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = SQ_X;
                end
            end
            SQ_X, SQ_Y: begin
                if (operand[bit_cnt_q]) begin
                    acc_d = acc_q + (ACC_W'(operand) << bit_cnt_q);
                end
                if (last_bit) begin
                    bit_cnt_d = '0;
                    state_d   = (state_q == SQ_X) ? SQ_Y : SAT;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            SAT: begin
                if ((acc_q >> OUT_WIDTH) != '0) begin
                    sq_out_d   = '1;
                    overflow_d = 1'b1;
                end else begin
                    sq_out_d   = acc_q[OUT_WIDTH-1:0];
                    overflow_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sq_out   = sq_out_q;
    assign overflow = overflow_q;
    assign done     = done_q;
    assign finish   = (state_q == IDLE);

endmodule

// File: tb/tb_dist_sq_seq.sv
// Self-checking bench for dist_sq_seq against an arithmetic reference model.
module tb_dist_sq_seq;

    logic        clk;
    logic        reset;
    logic [9:0]  x_in, y_in, cx_in, cy_in;
    logic        start;
    logic [11:0] sq_out;
    logic        overflow;
    logic        done;
    logic        finish;

    int checks = 0;
    int errors = 0;

    dist_sq_seq #(.COORD_WIDTH(10), .OUT_WIDTH(12)) dut (
        .clk      (clk),
        .reset    (reset),
        .x_in     (x_in),
        .y_in     (y_in),
        .cx_in    (cx_in),
        .cy_in    (cy_in),
        .start    (start),
        .sq_out   (sq_out),
        .overflow (overflow),
        .done     (done),
        .finish   (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic with saturation at 4095.
    function automatic int model_raw(input int x, input int y, input int cx, input int cy);
        int dx, dy;
        dx = (x > cx) ? x - cx : cx - x;
        dy = (y > cy) ? y - cy : cy - y;
        return dx * dx + dy * dy;
    endfunction

    function automatic int isqrt(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Behavioural stand-in for the sqrt stage: started by done, operand sq_out.
    int sqrt_result = -1;
    always @(posedge clk) if (done) sqrt_result <= isqrt(int'(sq_out));

    // Drive one request and wait (bounded) for done; returns result, latency, finish-low count.
    task automatic do_op(input int x, input int y, input int cx, input int cy,
                         output logic [11:0] sq, output logic ov,
                         output int lat, output int low);
        x_in = 10'(x); y_in = 10'(y); cx_in = 10'(cx); cy_in = 10'(cy);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; low = 0;
        while (!done && lat < 100) begin
            if (!finish) low++;
            @(posedge clk); #1;
            lat++;
        end
        sq = sq_out; ov = overflow;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        x_in = '0; y_in = '0; cx_in = '0; cy_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sq_out !== 12'd0 || overflow !== 1'b0 || done !== 1'b0 || finish !== 1'b1) begin
            errors++;
            $display("FAIL reset: sq=%0d ov=%b done=%b fin=%b required 0 0 0 1",
                     sq_out, overflow, done, finish);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [11:0] sq; logic ov; int lat, low;
        do_op(100, 50, 97, 46, sq, ov, lat, low);
        checks++;
        if (lat !== 21) begin
            errors++; $display("FAIL basic_latency: got %0d required 21", lat);
        end
        checks++;
        if (low !== 21) begin
            errors++; $display("FAIL basic_finish_low: got %0d required 21", low);
        end
        checks++;
        if (sq !== 12'd25 || ov !== 1'b0 || finish !== 1'b1) begin
            errors++; $display("FAIL basic_result: sq=%0d ov=%b fin=%b required 25 0 1", sq, ov, finish);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || sq_out !== 12'd25) begin
            errors++; $display("FAIL basic_done_pulse: done=%b sq=%0d required 0 25", done, sq_out);
        end
    endtask

    task automatic test_negative();
        logic [11:0] sq; logic ov; int lat, low;
        do_op(0, 3, 5, 15, sq, ov, lat, low);
        checks++;
        if (sq !== 12'd169 || ov !== 1'b0) begin
            errors++; $display("FAIL negative: sq=%0d ov=%b required 169 0", sq, ov);
        end
    endtask

    task automatic test_saturation();
        logic [11:0] sq; logic ov; int lat, low;
        do_op(63, 8, 0, 0, sq, ov, lat, low);
        checks++;
        if (sq !== 12'd4033 || ov !== 1'b0) begin
            errors++; $display("FAIL sat_4033: sq=%0d ov=%b required 4033 0", sq, ov);
        end
        do_op(200, 7, 264, 7, sq, ov, lat, low);
        checks++;
        if (sq !== 12'd4095 || ov !== 1'b1) begin
            errors++; $display("FAIL sat_4096: sq=%0d ov=%b required 4095 1", sq, ov);
        end
        do_op(1023, 1023, 0, 0, sq, ov, lat, low);
        checks++;
        if (sq !== 12'd4095 || ov !== 1'b1) begin
            errors++; $display("FAIL sat_max: sq=%0d ov=%b required 4095 1", sq, ov);
        end
    endtask

    task automatic test_busy();
        int n;
        int done_seen;
        x_in = 10'd3; cx_in = 10'd0; y_in = 10'd4; cy_in = 10'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        done_seen = 0;
        while (!done && n < 100) begin
            if (n == 5) begin
                x_in = 10'd900; cx_in = 10'd1; y_in = 10'd2; cy_in = 10'd700;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (n == 8) begin
                checks++;
                if (sq_out !== 12'd4095 || overflow !== 1'b1) begin
                    errors++; $display("FAIL busy_hold: sq=%0d ov=%b required 4095 1", sq_out, overflow);
                end
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        checks++;
        if (n !== 22 || sq_out !== 12'd25 || overflow !== 1'b0) begin
            errors++; $display("FAIL busy_result: edge=%0d sq=%0d ov=%b required 22 25 0",
                               n - 1, sq_out, overflow);
        end
        repeat (30) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        checks++;
        if (done_seen !== 0 || finish !== 1'b1) begin
            errors++; $display("FAIL busy_no_second: done_pulses=%0d fin=%b required 0 1", done_seen, finish);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] sq; logic ov; int lat, low;
        x_in = 10'd30; cx_in = 10'd0; y_in = 10'd40; cy_in = 10'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if (sq_out !== 12'd0 || overflow !== 1'b0 || finish !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL reset_mid: sq=%0d ov=%b fin=%b done=%b required 0 0 1 0",
                               sq_out, overflow, finish, done);
        end
        do_op(11, 20, 10, 21, sq, ov, lat, low);
        checks++;
        if (sq !== 12'd2 || ov !== 1'b0 || lat !== 21) begin
            errors++; $display("FAIL reset_mid_restart: sq=%0d ov=%b lat=%0d required 2 0 21", sq, ov, lat);
        end
    endtask

    task automatic test_chain();
        logic [11:0] sq; logic ov; int lat, low;
        do_op(30, 0, 0, 40, sq, ov, lat, low);
        @(posedge clk); #1;
        checks++;
        if (sq !== 12'd2500 || sqrt_result !== 50) begin
            errors++; $display("FAIL chain_sqrt: sq=%0d root=%0d required 2500 50", sq, sqrt_result);
        end
    endtask

    task automatic test_back_to_back();
        int gap, n;
        x_in = 10'd12; cx_in = 10'd7; y_in = 10'd1; cy_in = 10'd3;
        start = 1'b1;
        n = 0;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        gap = 0;
        @(posedge clk); #1;
        gap = 1;
        while (!done && gap < 100) begin @(posedge clk); #1; gap++; end
        start = 1'b0;
        checks++;
        if (gap !== 22 || sq_out !== 12'd29) begin
            errors++; $display("FAIL back_to_back: period=%0d sq=%0d required 22 29", gap, sq_out);
        end
        repeat (25) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [11:0] sq; logic ov; int lat, low;
        int x, y, cx, cy, d, raw;
        logic [11:0] exp_sq; logic exp_ov;
        for (int i = 0; i < 40; i++) begin
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 1023);
            if (i % 2 == 0) begin
                d = $urandom_range(0, 60);
                cx = (x >= d) ? x - d : x + d;
                d = $urandom_range(0, 60);
                cy = (y >= d) ? y - d : y + d;
            end else begin
                cx = $urandom_range(0, 1023);
                cy = $urandom_range(0, 1023);
            end
            raw = model_raw(x, y, cx, cy);
            exp_ov = (raw > 4095);
            exp_sq = exp_ov ? 12'd4095 : 12'(raw);
            do_op(x, y, cx, cy, sq, ov, lat, low);
            checks++;
            if (sq !== exp_sq || ov !== exp_ov || lat !== 21) begin
                errors++;
                $display("FAIL random[%0d]: x=%0d y=%0d cx=%0d cy=%0d sq=%0d ov=%b lat=%0d required %0d %b 21",
                         i, x, y, cx, cy, sq, ov, lat, exp_sq, exp_ov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_busy();
        test_reset_mid();
        test_chain();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
